addsub_seq_n: RTL

- Parametrised multi-cycle add/subtract unit: the sequential successor to the combinational n-bit subtractor.
- Processes an nb_bit operand pair chunk_bit bits per clock, carrying the borrow/carry between chunks.
- Serves mantissa/exponent datapaths where area matters more than latency.
- Valid/ready handshake on input and output.

---
 rtl/addsub_seq_n.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/addsub_seq_n.sv
// Multi-cycle add/subtract: chunk_bit bits per clock with carry kept between chunks, valid/ready on both sides.
// Optional ADDSUB_ABS_DIFF_EN: a negative difference is negated in a NEG pass, giving |A-B| with swap_o=1.
module addsub_seq_n #(
  parameter int nb_bit    = 24,
  parameter int chunk_bit = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [nb_bit-1:0] a_i,
  input  logic [nb_bit-1:0] b_i,
  input  logic              op_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [nb_bit-1:0] res_o,
  output logic              borrow_o,
`ifdef ADDSUB_ABS_DIFF_EN
  output logic              swap_o,
`endif
  output logic              zero_o
);

  localparam int NB_CHUNK = nb_bit / chunk_bit;
  localparam int KW = (NB_CHUNK > 1) ? $clog2(NB_CHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB_CHUNK - 1);

  generate
    if (nb_bit % chunk_bit != 0) begin : g_bad_chunk
      $error("addsub_seq_n: chunk_bit must divide nb_bit");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef ADDSUB_ABS_DIFF_EN
    NEG,
`endif
    DONE
  } state_t;

  state_t            state_q;
  logic [nb_bit-1:0] a_q, b_q;
  logic              op_q;
  logic              c_q;
  logic [KW-1:0]     k_q;

  logic [chunk_bit-1:0] x_ch, y_ch, sum_ch;
  logic                 c_nxt;
  logic [nb_bit-1:0]    res_nxt;
  int                   base;

  // One adder slice serves both the RUN pass (A +/- B) and the NEG pass (~res + c).
  always_comb begin
    base = int'(k_q) * chunk_bit;
    x_ch = a_q[base +: chunk_bit];
    y_ch = op_q ? b_q[base +: chunk_bit] : ~b_q[base +: chunk_bit];
`ifdef ADDSUB_ABS_DIFF_EN
    if (state_q == NEG) begin
      x_ch = ~res_o[base +: chunk_bit];
      y_ch = '0;
    end
`endif
    {c_nxt, sum_ch} = {1'b0, x_ch} + {1'b0, y_ch} + {{chunk_bit{1'b0}}, c_q};
    res_nxt = res_o;
    res_nxt[base +: chunk_bit] = sum_ch;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      res_o       <= '0;
      borrow_o    <= 1'b0;
      zero_o      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      c_q         <= 1'b0;
      k_q         <= '0;
`ifdef ADDSUB_ABS_DIFF_EN
      swap_o      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= b_i;
            op_q       <= op_i;
            c_q        <= ~op_i;
            k_q        <= '0;
            in_ready_o <= 1'b0;
            state_q    <= RUN;
`ifdef ADDSUB_ABS_DIFF_EN
            swap_o     <= 1'b0;
`endif
          end
        end
        RUN: begin
          res_o <= res_nxt;
          c_q   <= c_nxt;
          k_q   <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            k_q         <= '0;
            state_q     <= DONE;
            out_valid_o <= 1'b1;
            borrow_o    <= op_q ? c_nxt : ~c_nxt;
            zero_o      <= (res_nxt == '0);
`ifdef ADDSUB_ABS_DIFF_EN
            // No final carry on a subtract means A<B: divert through NEG instead.
            if (!op_q && !c_nxt) begin
              state_q     <= NEG;
              c_q         <= 1'b1;
              out_valid_o <= 1'b0;
            end
`endif
          end
        end
`ifdef ADDSUB_ABS_DIFF_EN
        NEG: begin
          res_o <= res_nxt;
          c_q   <= c_nxt;
          k_q   <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            k_q         <= '0;
            state_q     <= DONE;
            out_valid_o <= 1'b1;
            borrow_o    <= 1'b1;
            swap_o      <= 1'b1;
            zero_o      <= (res_nxt == '0);
          end
        end
`endif
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
